mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder with valid/ready request and response channels.
// A programmable number of wait states separates request acceptance from the response.
module mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 4 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two from 4 to 65536");
    end
    if (LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be from 0 to 15");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          exec;
    logic          addr_ok;
    logic          mem_we;
    logic [AW-1:0] word_idx;

    assign accept   = req_valid && (state_q == StIdle);
    assign exec     = (state_q == StWait) && (cnt_q == 4'd0);
    assign addr_ok  = (addr_q[1:0] == 2'b00) && (addr_q[31:2] < 30'(DEPTH));
    assign word_idx = addr_q[AW+1:2];
    // Reset wins over an access that would execute on the same edge.
    assign mem_we   = exec && write_q && addr_ok && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Storage is deliberately not reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StWait;
                    cnt_d   = 4'(LATENCY);
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                    err_d   = !addr_ok;
                    rdata_d = (addr_ok && !write_q) ? mem[word_idx] : 32'd0;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_rdata = rsp_valid ? rdata_q : 32'd0;
        rsp_err   = rsp_valid && err_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (LATENCY 2, 4, 0) share clock and reset;
// a driver pushes expected responses, a monitor pops and compares them when responses appear.
module tb_mem_responder;

    localparam int N = 3;

    typedef struct {
        int          inst;
        logic [31:0] d;
        logic        e;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_write [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_be    [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];

    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_responder #(
            .DEPTH  (256),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 4 : 0))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_write(req_write[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 4 : 0);
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst %0d: got %h, required %h", name, inst, act, exp);
        end
    endtask

    task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] ed, input bit ee,
                         input bit expect_rsp);
        int   n;
        exp_t x;
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_be[i]    = be;
        req_valid[i] = 1'b1;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout inst %0d: req_ready never 1", i);
        end else if (expect_rsp) begin
            x.inst = i;
            x.d    = ed;
            x.e    = ee;
            x.cyc  = cyc + 1 + lat_of(i) + 1;
            sb.push_back(x);
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compares a response on its first valid cycle, then checks it holds until taken.
    initial begin
        logic [31:0] held_d [N];
        logic        held_e [N];
        bit          vprev  [N];
        for (int i = 0; i < N; i++) vprev[i] = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (reset === 1'b1) begin
                    vprev[i] = 1'b0;
                end else if (rsp_valid[i] === 1'b1) begin
                    if (!vprev[i]) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_rsp inst %0d: rsp_valid 1, required 0", i);
                        end else begin
                            chk("rsp_inst", i, 32'(i), 32'(sb[0].inst));
                            chk("rsp_cycle", i, 32'(cyc), 32'(sb[0].cyc));
                            chk("rsp_rdata", i, rsp_rdata[i], sb[0].d);
                            chk("rsp_err", i, 32'(rsp_err[i]), 32'(sb[0].e));
                        end
                        held_d[i] = rsp_rdata[i];
                        held_e[i] = rsp_err[i];
                    end else begin
                        chk("hold_rdata", i, rsp_rdata[i], held_d[i]);
                        chk("hold_err", i, 32'(rsp_err[i]), 32'(held_e[i]));
                    end
                    if (rsp_ready[i] === 1'b1) begin
                        if (sb.size() != 0) void'(sb.pop_front());
                        vprev[i] = 1'b0;
                    end else begin
                        vprev[i] = 1'b1;
                    end
                end else begin
                    vprev[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] wtab [8];
        int          n;
        wtab = '{32'h0000_0001, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666,
                 32'h7777_8888, 32'h9999_AAAA, 32'hBBBB_CCCC, 32'hDDDD_EEEE};

        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_be[i]    = '0;
            rsp_ready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("reset_req_ready", i, 32'(req_ready[i]), 32'd1);
            chk("reset_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("reset_rsp_err", i, 32'(rsp_err[i]), 32'd0);
            chk("reset_rsp_rdata", i, rsp_rdata[i], 32'd0);
        end

        // Basic write/read, byte merge, errors and boundaries on the LATENCY=2 instance.
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, 1'b1);
        issue(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h0, 32'h0, 4'hF, 32'hA5A5_A5A5, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 1'b1);
        issue(0, 1'b1, 32'h3FC, 32'hCAFE_1234, 4'hF, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b1, 32'h3FE, 32'h0000_0000, 4'hF, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h3FC, 32'h0, 4'hF, 32'hCAFE_1234, 1'b0, 1'b1);
        drain();

        // Backpressure: response held for 5 cycles, then released.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, 1'b1);
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", 0, 32'(rsp_valid[0]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_req_ready", 0, 32'(req_ready[0]), 32'd0);
            chk("bp_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_req_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("bp_release_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        drain();

        // Reset two cycles after acceptance on the LATENCY=4 instance discards the write.
        issue(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b1);
        drain();
        issue(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wait_req_ready", 1, 32'(req_ready[1]), 32'd1);
        chk("rst_wait_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
        repeat (8) @(negedge clk);
        issue(1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
        drain();

        // LATENCY=0: fill 8 words, then 8 back-to-back reads with rsp_ready held high.
        for (int k = 0; k < 8; k++) begin
            issue(2, 1'b1, 32'h40 + 32'(4 * k), wtab[k], 4'hF, 32'h0, 1'b0, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            issue(2, 1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'hF, wtab[k], 1'b0, 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
